// File: rtl/seq_multiplier_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter must hold D_SIZE itself, hence +1 before the log.
  function automatic int cnt_w(input int d_size);
    return $clog2(d_size + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier.
interface seq_multiplier_if #(
  parameter int D_SIZE = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [D_SIZE-1:0]     multicand;
  logic [D_SIZE-1:0]     multiplier;
  logic                  is_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*D_SIZE-1:0]   product;

  // Operand producer / result consumer side.
  modport master (
    output in_valid, multicand, multiplier, is_signed, out_ready,
    input  in_ready, out_valid, product
  );

  // Multiplier side.
  modport slave (
    input  in_valid, multicand, multiplier, is_signed, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one D_SIZE x D_SIZE product every
// D_SIZE+1 cycles with a single adder. Signed mode multiplies magnitudes
// and negates the final product when the operand signs differ.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int D_SIZE = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_multiplier_if.slave bus
);

  localparam int CW = cnt_w(D_SIZE);

  state_t                state, state_nxt;
  logic                  accept;
  logic [CW-1:0]         cnt;
  logic [D_SIZE-1:0]     mcand_q;
  logic [D_SIZE-1:0]     mplier_q;
  logic [D_SIZE-1:0]     acc_q;
  logic                  neg_q;
  logic [2*D_SIZE-1:0]   product_q;
  logic [D_SIZE-1:0]     addend;
  logic [D_SIZE:0]       sum;
  logic [2*D_SIZE-1:0]   mag;
  logic [2*D_SIZE-1:0]   prod_nxt;
  logic [D_SIZE-1:0]     a_abs;
  logic [D_SIZE-1:0]     b_abs;

  // Two's-complement magnitude; the most-negative value maps to
  // 2^(D_SIZE-1), which still fits in D_SIZE unsigned bits.
  function automatic logic [D_SIZE-1:0] magnitude(input logic [D_SIZE-1:0] v,
                                                  input logic              sgn);
    return (sgn && v[D_SIZE-1]) ? -v : v;
  endfunction

  assign accept      = bus.in_valid && bus.in_ready;
  assign a_abs       = magnitude(bus.multicand, bus.is_signed);
  assign b_abs       = magnitude(bus.multiplier, bus.is_signed);
  assign bus.product = product_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; DONE releases in_ready when the
  // consumer takes the result so a new operation can start on that edge.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) state_nxt = bus.in_valid ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One shift-add step: conditional add into the upper half, then shift
  // {carry, acc, mplier} right by one. mag is the full magnitude after the
  // step, used only on the final iteration.
  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    sum      = {1'b0, acc_q} + {1'b0, addend};
    mag      = {sum, mplier_q[D_SIZE-1:1]};
    prod_nxt = neg_q ? -mag : mag;
  end

  // Datapath: load on accept, iterate while BUSY, publish product only on
  // the edge entering DONE so it stays stable otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else if (accept) begin
      cnt      <= CW'(D_SIZE);
      mcand_q  <= a_abs;
      mplier_q <= b_abs;
      acc_q    <= '0;
      neg_q    <= bus.is_signed &&
                  (bus.multicand[D_SIZE-1] ^ bus.multiplier[D_SIZE-1]);
    end else if (state == BUSY) begin
      cnt      <= cnt - CW'(1);
      acc_q    <= sum[D_SIZE:1];
      mplier_q <= {sum[0], mplier_q[D_SIZE-1:1]};
      if (cnt == CW'(1)) product_q <= prod_nxt;
    end
  end

endmodule
